// File: rtl/uart_pkg.sv
// Definitions shared by both UART directions: FSM state codes, parity modes, held-frame layout.
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam string PARITY_NONE = "NONE";
  localparam string PARITY_ODD  = "ODD";
  localparam string PARITY_EVEN = "EVEN";

  // Seed for the running XOR: the check passes when the accumulator ends at 0.
  localparam logic PARITY_INIT_ODD  = 1'b1;
  localparam logic PARITY_INIT_EVEN = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic       parity_err;
    logic       frame_err;
  } rx_frame_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive handshake bundle: the receiver (master) holds a frame under valid, the consumer (slave) answers with ready.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  modport master (output data, valid, parity_err, frame_err, overrun, input ready);
  modport slave  (input data, valid, parity_err, frame_err, overrun, output ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; two clocks of latency, reset loads RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, optional parity, 1-2 stop bits; valid rises the edge after the last stop sample.
// A frame finishing while the held one is unaccepted is dropped with a one-cycle overrun pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter string       PARITY       = "NONE",
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned BAUD_DIVIDER = 65535
) (
  input  logic      clk_in,
  input  logic      reset,
  input  logic      rxd_in,
  uart_rx_if.master host
);

  localparam logic        PAR_EN    = (PARITY != PARITY_NONE);
  localparam logic        PAR_INIT  = (PARITY == PARITY_ODD) ? PARITY_INIT_ODD : PARITY_INIT_EVEN;
  localparam logic [15:0] HALF_TICK = 16'(BAUD_DIVIDER / 2 - 1);
  localparam logic [15:0] FULL_TICK = 16'(BAUD_DIVIDER - 1);
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  logic        rxd_s;
  logic        rxd_prev_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        ferr_q, ferr_d;
  logic        frame_done;
  logic        bit_tick;
  rx_frame_t   new_frame;
  rx_frame_t   out_q, out_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d_i    (rxd_in),
    .q_o    (rxd_s)
  );

  assign bit_tick = (div_cnt_q == FULL_TICK);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        // Edge-triggered so a line parked low (break) cannot retrigger.
        if (rxd_prev_q && !rxd_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (div_cnt_q == HALF_TICK) begin
          div_cnt_d = '0;
          if (rxd_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
            par_d     = PAR_INIT;
            ferr_d    = 1'b0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          div_cnt_d          = '0;
          shift_d[bit_cnt_q] = rxd_s;
          par_d              = par_q ^ rxd_s;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end

      S_PARITY: begin
        if (bit_tick) begin
          div_cnt_d = '0;
          par_d     = par_q ^ rxd_s;
          state_d   = S_STOP;
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          div_cnt_d = '0;
          if (!rxd_s) begin
            ferr_d = 1'b1;
          end
          // Leave at mid-stop-bit so the following start edge is never missed.
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d  = '0;
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        div_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    new_frame.data       = shift_q;
    new_frame.parity_err = PAR_EN & par_q;
    new_frame.frame_err  = ferr_q | ~rxd_s;
  end

  always_comb begin
    out_d     = out_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (frame_done) begin
      if (!valid_q || host.ready) begin
        out_d   = new_frame;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && host.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rxd_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxd_prev_q <= rxd_s;
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_q     <= ferr_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign host.data       = out_q.data;
  assign host.parity_err = out_q.parity_err;
  assign host.frame_err  = out_q.frame_err;
  assign host.valid      = valid_q;
  assign host.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 receiver on line A and an 8E1 receiver on line B, 16 clocks per bit.
module tb_uart_rx;

  localparam int BIT = 16;

  logic clk_in = 1'b0;
  logic reset;
  logic rxd_a;
  logic rxd_b;

  always #5 clk_in = ~clk_in;

  uart_rx_if if_a ();
  uart_rx_if if_b ();

  uart_rx #(
    .DATA_BITS    (8),
    .PARITY       ("NONE"),
    .STOP_BITS    (1),
    .BAUD_DIVIDER (16)
  ) dut_a (
    .clk_in (clk_in),
    .reset  (reset),
    .rxd_in (rxd_a),
    .host   (if_a)
  );

  uart_rx #(
    .DATA_BITS    (8),
    .PARITY       ("EVEN"),
    .STOP_BITS    (1),
    .BAUD_DIVIDER (16)
  ) dut_b (
    .clk_in (clk_in),
    .reset  (reset),
    .rxd_in (rxd_b),
    .host   (if_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Observers: handshakes, valid rising edges and overrun-high cycles.
  int         acc_a = 0, rise_a = 0, ovr_a = 0, rise_cyc_a = 0, acc_b = 0;
  logic       vprev_a = 1'b0;
  logic [7:0] last_data_a = '0, last_data_b = '0;
  logic       last_pe_a = 1'b0, last_fe_a = 1'b0, last_pe_b = 1'b0, last_fe_b = 1'b0;

  always @(negedge clk_in) begin
    if (if_a.valid && !vprev_a) begin
      rise_a     <= rise_a + 1;
      rise_cyc_a <= cyc;
    end
    vprev_a <= if_a.valid;
    if (if_a.valid && if_a.ready) begin
      acc_a       <= acc_a + 1;
      last_data_a <= if_a.data;
      last_pe_a   <= if_a.parity_err;
      last_fe_a   <= if_a.frame_err;
    end
    if (if_a.overrun) ovr_a <= ovr_a + 1;
    if (if_b.valid && if_b.ready) begin
      acc_b       <= acc_b + 1;
      last_data_b <= if_b.data;
      last_pe_b   <= if_b.parity_err;
      last_fe_b   <= if_b.frame_err;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input logic par_bit, input logic stop_bit);
    drive(sel, 1'b0);
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      tick(BIT);
    end
    if (with_par) begin
      drive(sel, par_bit);
      tick(BIT);
    end
    drive(sel, stop_bit);
    tick(BIT);
    drive(sel, 1'b1);
  endtask

  int         base_acc, base_rise, base_ovr, start_cyc, lat;
  logic [7:0] v5a;

  initial begin
    reset      = 1'b1;
    rxd_a      = 1'b1;
    rxd_b      = 1'b1;
    if_a.ready = 1'b1;
    if_b.ready = 1'b1;
    tick(4);

    check("rst_valid_a",   int'(if_a.valid),      0);
    check("rst_data_a",    int'(if_a.data),       0);
    check("rst_perr_a",    int'(if_a.parity_err), 0);
    check("rst_ferr_a",    int'(if_a.frame_err),  0);
    check("rst_overrun_a", int'(if_a.overrun),    0);
    check("rst_valid_b",   int'(if_b.valid),      0);

    reset = 1'b0;
    tick(BIT);

    // 0xA5, 8N1, with start-edge to valid latency.
    base_acc  = acc_a;
    base_rise = rise_a;
    start_cyc = cyc;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    tick(BIT);
    check("a5_accepts", acc_a - base_acc, 1);
    check("a5_valids",  rise_a - base_rise, 1);
    check("a5_data",    int'(last_data_a), 'hA5);
    check("a5_perr",    int'(last_pe_a), 0);
    check("a5_ferr",    int'(last_fe_a), 0);
    lat = rise_cyc_a - start_cyc;
    checks++;
    assert (lat >= 150 && lat <= 156) else begin
      errors++;
      $error("FAIL a5_latency: observed %0d required 150..156", lat);
    end

    // Four-clock glitch must be rejected, then 0x3C received.
    base_rise = rise_a;
    drive(1'b0, 1'b0);
    tick(4);
    drive(1'b0, 1'b1);
    tick(3 * BIT);
    check("glitch_no_valid", rise_a - base_rise, 0);
    base_acc = acc_a;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    tick(BIT);
    check("3c_accepts", acc_a - base_acc, 1);
    check("3c_data",    int'(last_data_a), 'h3C);
    check("3c_ferr",    int'(last_fe_a), 0);

    // Even parity: 0x01 with parity 0 is wrong, 0x03 with parity 0 is right.
    base_acc = acc_b;
    send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    tick(BIT);
    check("even01_accepts", acc_b - base_acc, 1);
    check("even01_data",    int'(last_data_b), 'h01);
    check("even01_perr",    int'(last_pe_b), 1);
    check("even01_ferr",    int'(last_fe_b), 0);
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    tick(BIT);
    check("even03_data", int'(last_data_b), 'h03);
    check("even03_perr", int'(last_pe_b), 0);

    // Break: 20 bit times low gives exactly one 0x00 frame with frame_err.
    base_rise = rise_a;
    drive(1'b0, 1'b0);
    tick(20 * BIT);
    drive(1'b0, 1'b1);
    tick(3 * BIT);
    check("break_valids", rise_a - base_rise, 1);
    check("break_data",   int'(last_data_a), 0);
    check("break_ferr",   int'(last_fe_a), 1);
    send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
    tick(BIT);
    check("7e_data", int'(last_data_a), 'h7E);
    check("7e_ferr", int'(last_fe_a), 0);
    check("7e_perr", int'(last_pe_a), 0);

    // Overrun: hold 0x11 with ready low, drop 0x22.
    if_a.ready = 1'b0;
    base_acc   = acc_a;
    base_ovr   = ovr_a;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    tick(BIT);
    check("hold_valid", int'(if_a.valid), 1);
    check("hold_data",  int'(if_a.data), 'h11);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    tick(BIT);
    check("ovr_valid",   int'(if_a.valid), 1);
    check("ovr_data",    int'(if_a.data), 'h11);
    check("ovr_pulse",   ovr_a - base_ovr, 1);
    check("ovr_accepts", acc_a - base_acc, 0);
    if_a.ready = 1'b1;
    tick(2);
    check("ovr_drain_valid",   int'(if_a.valid), 0);
    check("ovr_drain_accepts", acc_a - base_acc, 1);
    check("ovr_drain_data",    int'(last_data_a), 'h11);

    // Reset during data bit 3 discards the frame.
    v5a       = 8'h5A;
    base_rise = rise_a;
    drive(1'b0, 1'b0);
    tick(BIT);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, v5a[i]);
      tick(BIT);
    end
    drive(1'b0, v5a[3]);
    tick(BIT / 2);
    reset = 1'b1;
    drive(1'b0, 1'b1);
    tick(2);
    reset = 1'b0;
    tick(3 * BIT);
    check("midrst_valids", rise_a - base_rise, 0);
    check("midrst_valid",  int'(if_a.valid), 0);
    check("midrst_perr",   int'(if_a.parity_err), 0);
    check("midrst_ferr",   int'(if_a.frame_err), 0);
    base_acc = acc_a;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    tick(BIT);
    check("5a_accepts", acc_a - base_acc, 1);
    check("5a_data",    int'(last_data_a), 'h5A);
    check("5a_ferr",    int'(last_fe_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
